// File: rtl/seg7_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture_if
//  Purpose  : Bundles the sampled display lines and the published read-back
//             value of seg7_capture.
//  Signals  : seg_in[6:0]  segment lines (bit0=a .. bit6=g), raw polarity
//             dig_in[1:0]  digit strobes (bit0=ones, bit1=tens), raw polarity
//             pol          1: lines active-high, 0: active-low
//             digit1[3:0]  published ones digit (BCD)
//             digit10[3:0] published tens digit (BCD, 0 when blank)
//             tens_blank   published tens digit was blank
//             valid        a value has been published since reset
//             update       one-cycle pulse on each publish
//             err          one-cycle pulse when a frame is discarded
//  Modports : master = display side / bench, slave = seg7_capture
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_capture_if;
    logic [6:0] seg_in;
    logic [1:0] dig_in;
    logic       pol;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic       tens_blank;
    logic       valid;
    logic       update;
    logic       err;

    modport master (
        output seg_in, dig_in, pol,
        input  digit1, digit10, tens_blank, valid, update, err
    );

    modport slave (
        input  seg_in, dig_in, pol,
        output digit1, digit10, tens_blank, valid, update, err
    );
endinterface
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture
//  Purpose  : Reads back a two-digit multiplexed seven-segment display.
//             Synchronizes the segment/strobe lines, waits for each digit to
//             settle, decodes glyphs to BCD and publishes a value once it has
//             been seen in CONFIRM consecutive identical frames.
//  Ports    : clk  - single clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - seg7_capture_if.slave (display inputs, published value)
//  Revision : 1.0  initial release
// ============================================================================
module seg7_capture #(
    parameter int SETTLE       = 4,
    parameter int TENS_TIMEOUT = 64,
    parameter int CONFIRM      = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    seg7_capture_if.slave   bus
);

    localparam int STAB_W  = ($clog2(SETTLE + 1) > 3) ? $clog2(SETTLE + 1) : 3;
    localparam int TMR_W   = $clog2(TENS_TIMEOUT + 1);
    localparam int MATCH_W = ($clog2(CONFIRM + 1) > 1) ? $clog2(CONFIRM + 1) : 1;

    typedef enum logic [1:0] {
        WAIT_ONES = 2'd0,
        WAIT_TENS = 2'd1,
        FRAME     = 2'd2
    } state_t;

    // Returns {glyph_ok, bcd}; any pattern outside the ten digits is invalid.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    logic [6:0]         seg_s1, seg_s2, prev_seg;
    logic [1:0]         dig_s1, dig_s2, prev_strb;
    logic [STAB_W-1:0]  stab;
    logic               settled_d;
    logic [TMR_W-1:0]   timer;
    logic [MATCH_W-1:0] match;
    logic [8:0]         prev_frame;
    logic [3:0]         cand1, cand10;
    logic               blank;
    state_t             state;

    logic [3:0]         digit1, digit10;
    logic               tens_blank, valid, update, err;

    logic [6:0]         seg;
    logic [1:0]         strb;
    logic               changed;
    logic               at_settle;
    logic               fire;
    logic [4:0]         dec;
    logic [8:0]         frame_val;
    logic [MATCH_W-1:0] next_match;

    always_comb begin
        seg       = seg_s2 ^ {7{~bus.pol}};
        strb      = dig_s2 ^ {2{~bus.pol}};
        changed   = (seg != prev_seg) || (strb != prev_strb);
        at_settle = (stab == STAB_W'(SETTLE));
        // Capture only on the first settled cycle; the saturated counter
        // would otherwise re-trigger for as long as the strobe is held.
        fire      = at_settle && !settled_d;
        dec       = decode(seg);
        frame_val = {blank, cand10, cand1};
        if (frame_val != prev_frame)
            next_match = MATCH_W'(1);
        else if (match == MATCH_W'(CONFIRM))
            next_match = match;
        else
            next_match = match + MATCH_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1     <= '0;
            seg_s2     <= '0;
            dig_s1     <= '0;
            dig_s2     <= '0;
            prev_seg   <= '0;
            prev_strb  <= '0;
            stab       <= '0;
            settled_d  <= 1'b0;
            timer      <= '0;
            match      <= '0;
            prev_frame <= '0;
            cand1      <= '0;
            cand10     <= '0;
            blank      <= 1'b0;
            state      <= WAIT_ONES;
            digit1     <= '0;
            digit10    <= '0;
            tens_blank <= 1'b0;
            valid      <= 1'b0;
            update     <= 1'b0;
            err        <= 1'b0;
        end else begin
            seg_s1    <= bus.seg_in;
            seg_s2    <= seg_s1;
            dig_s1    <= bus.dig_in;
            dig_s2    <= dig_s1;
            prev_seg  <= seg;
            prev_strb <= strb;
            settled_d <= at_settle;
            update    <= 1'b0;
            err       <= 1'b0;

            if (changed)
                stab <= '0;
            else if (!at_settle)
                stab <= stab + STAB_W'(1);

            // The tens timer keeps running through dark periods and repeated
            // ones strobes; only a fresh ones capture restarts it.
            if (state == WAIT_TENS)
                timer <= timer + TMR_W'(1);

            if (fire && strb == 2'b11) begin
                err   <= 1'b1;
                match <= '0;
                state <= WAIT_ONES;
            end else begin
                case (state)
                    WAIT_ONES: begin
                        if (fire && strb == 2'b01) begin
                            if (dec[4]) begin
                                cand1 <= dec[3:0];
                                timer <= '0;
                                state <= WAIT_TENS;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    WAIT_TENS: begin
                        if (fire && strb == 2'b10) begin
                            if (dec[4]) begin
                                // A displayed leading zero counts as tens=0.
                                cand10 <= dec[3:0];
                                blank  <= 1'b0;
                                state  <= FRAME;
                            end else begin
                                err   <= 1'b1;
                                state <= WAIT_ONES;
                            end
                        end else if (timer == TMR_W'(TENS_TIMEOUT)) begin
                            cand10 <= '0;
                            blank  <= 1'b1;
                            state  <= FRAME;
                        end
                    end
                    FRAME: begin
                        prev_frame <= frame_val;
                        match      <= next_match;
                        if (next_match == MATCH_W'(CONFIRM) &&
                            (!valid || frame_val != {tens_blank, digit10, digit1})) begin
                            digit1     <= cand1;
                            digit10    <= cand10;
                            tens_blank <= blank;
                            valid      <= 1'b1;
                            update     <= 1'b1;
                        end
                        state <= WAIT_ONES;
                    end
                    default: state <= WAIT_ONES;
                endcase
            end
        end
    end

    assign bus.digit1     = digit1;
    assign bus.digit10    = digit10;
    assign bus.tens_blank = tens_blank;
    assign bus.valid      = valid;
    assign bus.update     = update;
    assign bus.err        = err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture
//  Purpose  : Self-checking bench for seg7_capture: a table of frame scenarios
//             followed by hand-written multi-cycle corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_capture;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_capture_if bus();

    seg7_capture #(.SETTLE(4), .TENS_TIMEOUT(TO), .CONFIRM(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int upd_total = 0;
    int err_total = 0;
    int both_total = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.update) upd_total <= upd_total + 1;
            if (bus.err)    err_total <= err_total + 1;
            if (bus.update && bus.err) both_total <= both_total + 1;
        end
    end

    typedef struct {
        logic       pol;
        logic [6:0] ones_g;
        logic [6:0] tens_g;
        logic       has_tens;
        int         nframes;
        int         exp_upd;
        logic [3:0] exp_d1;
        logic [3:0] exp_d10;
        logic       exp_blank;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int d1, input int d10,
                             input int blank, input int vld);
        check({name, " digit1"},     int'(bus.digit1),     d1);
        check({name, " digit10"},    int'(bus.digit10),    d10);
        check({name, " tens_blank"}, int'(bus.tens_blank), blank);
        check({name, " valid"},      int'(bus.valid),      vld);
    endtask

    // Drives active-high strobe/glyph values, inverted when pol=0.
    task automatic drive(input logic [1:0] s, input logic [6:0] g, input int n);
        bus.dig_in = bus.pol ? s : ~s;
        bus.seg_in = bus.pol ? g : ~g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] og, input logic [6:0] tg, input logic ht);
        drive(2'b01, og, 8);
        if (ht) drive(2'b10, tg, 8);
        else    drive(2'b00, 7'h00, TO + 16);
        drive(2'b00, 7'h00, 6);
    endtask

    int u0, e0;

    initial begin
        vecs[0] = '{1'b1, 7'h3F, 7'h5B, 1'b1, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 7'h3F, 7'h5B, 1'b1, 2, 1, 4'd0, 4'd2, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 7'h4F, 7'h00, 1'b0, 2, 1, 4'd3, 4'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 7'h06, 7'h06, 1'b1, 2, 1, 4'd1, 4'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 7'h3F, 7'h3F, 1'b1, 2, 1, 4'd0, 4'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 7'h6F, 7'h7F, 1'b1, 3, 1, 4'd9, 4'd8, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 7'h07, 7'h66, 1'b1, 2, 1, 4'd7, 4'd4, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 7'h6D, 7'h7D, 1'b1, 2, 1, 4'd5, 4'd6, 1'b0, 1'b1};

        bus.pol    = 1'b1;
        bus.dig_in = 2'b00;
        bus.seg_in = 7'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 0);
        check("reset update", int'(bus.update), 0);
        check("reset err",    int'(bus.err),    0);
        rst = 1'b0;
        drive(2'b00, 7'h00, 8);

        // ---------------- table-driven frame scenarios ----------------
        for (int i = 0; i < 8; i++) begin
            bus.pol = vecs[i].pol;
            drive(2'b00, 7'h00, 8);
            u0 = upd_total;
            e0 = err_total;
            for (int f = 0; f < vecs[i].nframes; f++)
                frame(vecs[i].ones_g, vecs[i].tens_g, vecs[i].has_tens);
            check($sformatf("vec%0d updates", i), upd_total - u0, vecs[i].exp_upd);
            check($sformatf("vec%0d errs", i), err_total - e0, 0);
            check_out($sformatf("vec%0d", i), vecs[i].exp_d1, vecs[i].exp_d10,
                      vecs[i].exp_blank, vecs[i].exp_valid);
        end

        // ---------------- 12, then 12/13/12, then 11/11 ----------------
        bus.pol = 1'b1;
        drive(2'b00, 7'h00, 8);
        u0 = upd_total;
        frame(7'h5B, 7'h06, 1'b1);
        frame(7'h5B, 7'h06, 1'b1);
        check("pub12 updates", upd_total - u0, 1);
        check_out("pub12", 2, 1, 0, 1);
        u0 = upd_total;
        frame(7'h5B, 7'h06, 1'b1);
        frame(7'h4F, 7'h06, 1'b1);
        frame(7'h5B, 7'h06, 1'b1);
        check("alt 12/13/12 updates", upd_total - u0, 0);
        u0 = upd_total;
        frame(7'h06, 7'h06, 1'b1);
        frame(7'h06, 7'h06, 1'b1);
        check("pub11 updates", upd_total - u0, 1);
        check_out("pub11", 1, 1, 0, 1);

        // ---------------- invalid ones glyph ----------------
        u0 = upd_total;
        e0 = err_total;
        drive(2'b01, 7'h49, 8);
        drive(2'b00, 7'h00, 6);
        check("bad glyph errs", err_total - e0, 1);
        check("bad glyph updates", upd_total - u0, 0);
        check_out("bad glyph", 1, 1, 0, 1);

        // ---------------- both strobes: err and match cleared ----------------
        u0 = upd_total;
        frame(7'h5B, 7'h5B, 1'b1);
        e0 = err_total;
        drive(2'b11, 7'h3F, 8);
        drive(2'b00, 7'h00, 6);
        check("strb11 errs", err_total - e0, 1);
        frame(7'h5B, 7'h5B, 1'b1);
        check("strb11 match cleared", upd_total - u0, 0);
        frame(7'h5B, 7'h5B, 1'b1);
        check("pub22 updates", upd_total - u0, 1);
        check_out("pub22", 2, 2, 0, 1);

        // ---------------- short strobe and toggling segments ----------------
        u0 = upd_total;
        frame(7'h66, 7'h00, 1'b0);
        drive(2'b01, 7'h66, 4);
        drive(2'b00, 7'h00, TO + 16);
        check("short strobe updates", upd_total - u0, 0);
        for (int k = 0; k < 8; k++)
            drive(2'b01, (k % 2 == 0) ? 7'h66 : 7'h6F, 2);
        drive(2'b00, 7'h00, TO + 16);
        check("toggle updates", upd_total - u0, 0);
        frame(7'h66, 7'h00, 1'b0);
        check("pub_b4 updates", upd_total - u0, 1);
        check_out("pub_b4", 4, 0, 1, 1);

        // ---------------- reset mid-WAIT_TENS ----------------
        u0 = upd_total;
        frame(7'h3F, 7'h5B, 1'b1);
        frame(7'h3F, 7'h5B, 1'b1);
        check("pub20 updates", upd_total - u0, 1);
        check_out("pub20", 0, 2, 0, 1);
        drive(2'b01, 7'h3F, 8);
        drive(2'b00, 7'h00, 10);
        #2 rst = 1'b1;
        #1;
        check_out("mid reset", 0, 0, 0, 0);
        check("mid reset update", int'(bus.update), 0);
        drive(2'b00, 7'h00, 3);
        rst = 1'b0;
        drive(2'b00, 7'h00, 6);
        u0 = upd_total;
        frame(7'h3F, 7'h5B, 1'b1);
        check("post reset 1 frame updates", upd_total - u0, 0);
        check("post reset 1 frame valid", int'(bus.valid), 0);
        frame(7'h3F, 7'h5B, 1'b1);
        check("post reset 2 frames updates", upd_total - u0, 1);
        check_out("post reset pub20", 0, 2, 0, 1);

        check("update with err", both_total, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
